// File: rtl/led_mode_sequencer.sv
// Button-driven LED mode sequencer: sync, tick debounce, press edge, mode FSM, blink phase.
// Optional long-press force-to-OFF is built when LED_SEQ_LONGPRESS_EN is defined.
module led_mode_sequencer #(
  parameter int unsigned TICK_DIV       = 16000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned SLOW_HALF      = 500,
  parameter int unsigned FAST_HALF      = 125,
  parameter int unsigned LONG_TICKS     = 1500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic       o_led,
  output logic [1:0] o_mode,
  output logic       o_press
);

  typedef enum logic [1:0] {ModeOff, ModeOn, ModeSlow, ModeFast} mode_e;

  localparam int unsigned PresW   = $clog2(TICK_DIV);
  localparam int unsigned DbW     = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned MaxHalf = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned PhW     = $clog2(MaxHalf + 1);

  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_TICKS - 1);
  localparam logic [PhW-1:0]   SlowLast = PhW'(SLOW_HALF - 1);
  localparam logic [PhW-1:0]   FastLast = PhW'(FAST_HALF - 1);

  logic [1:0]       r_sync;
  logic [PresW-1:0] r_presc;
  logic [DbW-1:0]   r_db_cnt;
  logic             r_db_lvl;
  logic             r_armed;
  logic             r_press;
  logic             r_led;
  logic [PhW-1:0]   r_phase;
  mode_e            r_mode;

  logic             w_btn_s;
  logic             w_tick;
  logic [DbW-1:0]   w_db_cnt_d;
  logic             w_db_lvl_d;
  logic             w_armed_d;
  logic             w_rise;
  logic             w_force;
  logic             w_mode_chg;
  mode_e            w_mode_d;
  logic             w_led_d;
  logic [PhW-1:0]   w_phase_d;
  logic [PhW-1:0]   w_half_last;

  assign w_btn_s = r_sync[1];
  assign w_tick  = (r_presc == PresLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_presc <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // A press is only reported once the button has been seen low since reset, so a
  // button held through reset release needs a real release and re-press.
  always_comb begin
    w_db_cnt_d = r_db_cnt;
    w_db_lvl_d = r_db_lvl;
    w_armed_d  = r_armed;
    if (w_tick) begin
      if (!w_btn_s) w_armed_d = 1'b1;
      if (w_btn_s == r_db_lvl) begin
        w_db_cnt_d = '0;
      end else if (r_db_cnt == DbLast) begin
        w_db_lvl_d = w_btn_s;
        w_db_cnt_d = '0;
      end else begin
        w_db_cnt_d = r_db_cnt + 1'b1;
      end
    end
  end

  assign w_rise = w_db_lvl_d & ~r_db_lvl & r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt <= '0;
      r_db_lvl <= 1'b0;
      r_armed  <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_db_cnt <= w_db_cnt_d;
      r_db_lvl <= w_db_lvl_d;
      r_armed  <= w_armed_d;
      r_press  <= w_rise;
    end
  end

`ifdef LED_SEQ_LONGPRESS_EN
  localparam int unsigned    HoldW    = $clog2(LONG_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);

  logic [HoldW-1:0] r_hold;

  // Saturating at LONG_TICKS gives exactly one force per hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (!r_db_lvl) begin
      r_hold <= '0;
    end else if (w_tick && (r_hold != HoldMax)) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign w_force = w_tick & r_db_lvl & (r_hold == HoldLast);
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= ModeOff;
    end else begin
      r_mode <= w_mode_d;
    end
  end

  always_comb begin
    w_mode_d = r_mode;
    if (w_force) begin
      w_mode_d = ModeOff;
    end else if (w_rise) begin
      w_mode_d = mode_e'(r_mode + 2'd1);
    end
  end

  assign w_mode_chg  = w_force | w_rise;
  assign w_half_last = (r_mode == ModeSlow) ? SlowLast : FastLast;

  // Mode change outranks a coincident blink toggle and restarts the half-period.
  always_comb begin
    w_led_d   = r_led;
    w_phase_d = r_phase;
    if (w_mode_chg) begin
      w_phase_d = '0;
      w_led_d   = (w_mode_d != ModeOff);
    end else begin
      unique case (r_mode)
        ModeOff: w_led_d = 1'b0;
        ModeOn:  w_led_d = 1'b1;
        ModeSlow, ModeFast: begin
          if (w_tick) begin
            if (r_phase == w_half_last) begin
              w_phase_d = '0;
              w_led_d   = ~r_led;
            end else begin
              w_phase_d = r_phase + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led   <= 1'b0;
      r_phase <= '0;
    end else begin
      r_led   <= w_led_d;
      r_phase <= w_phase_d;
    end
  end

  assign o_led   = r_led;
  assign o_mode  = r_mode;
  assign o_press = r_press;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: tick-level behavioural model checked every cycle,
// plus directed literal checks of press latency, blink intervals, reset and long press.
module tb_led_mode_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned SH = 8;
  localparam int unsigned FH = 2;
  localparam int unsigned LT = 20;

`ifdef LED_SEQ_LONGPRESS_EN
  localparam int LongEn = 1;
`else
  localparam int LongEn = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       press;

  int checks = 0;
  int errors = 0;
  int n_press = 0;

  led_mode_sequencer #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB),
    .SLOW_HALF     (SH),
    .FAST_HALF     (FH),
    .LONG_TICKS    (LT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (btn),
    .o_led  (led),
    .o_mode (mode),
    .o_press(press)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: cycles since reset, sync pipe, debounced level, consecutive differing
  // samples, armed flag, ticks held, mode and ticks since mode entry.
  int m_cyc, m_s1, m_s2, m_lvl, m_diff, m_armed, m_held, m_mode, m_t, m_press;

  function automatic int led_for(input int md, input int t);
    case (md)
      1:       return 1;
      2:       return ((t / SH) % 2 == 0) ? 1 : 0;
      3:       return ((t / FH) % 2 == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  initial forever begin : model
    int tick, bs, lvl_old, rise, frc;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cyc = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_diff = 0; m_armed = 0;
      m_held = 0; m_mode = 0; m_t = 0; m_press = 0;
    end else begin
      tick = ((m_cyc % TD) == TD - 1) ? 1 : 0;
      m_cyc++;
      bs = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(btn);
      lvl_old = m_lvl;
      rise = 0;
      frc = 0;
      if (tick != 0) begin
        if (lvl_old != 0) begin
          m_held++;
          if (m_held == LT && LongEn != 0) frc = 1;
        end else begin
          m_held = 0;
        end
        if (bs != m_lvl) begin
          m_diff++;
          if (m_diff == DB) begin
            m_lvl = bs;
            m_diff = 0;
            if (bs == 1 && m_armed != 0) rise = 1;
          end
        end else begin
          m_diff = 0;
        end
        if (bs == 0) m_armed = 1;
      end
      if (rise != 0) begin
        m_mode = (m_mode + 1) % 4;
        m_t = 0;
      end else if (frc != 0) begin
        m_mode = 0;
        m_t = 0;
      end else if (tick != 0) begin
        m_t++;
      end
      m_press = rise;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    check("model_led", int'(led), led_for(m_mode, m_t));
    check("model_mode", int'(mode), m_mode);
    check("model_press", int'(press), m_press);
    if (press) n_press++;
  end

  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic wait_press(output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (press) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic led_interval(output int n);
    logic lv;
    lv = led;
    n = 0;
    while (led == lv && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_press(input int exp_mode, input int half_cycles);
    int ok, n;
    btn = 1'b1;
    wait_press(ok);
    check("press_seen", ok, 1);
    check("press_mode", int'(mode), exp_mode);
    check("press_led", int'(led), (exp_mode != 0) ? 1 : 0);
    btn = 1'b0;
    if (half_cycles > 0) begin
      led_interval(n);
      check("first_half", n, half_cycles);
      led_interval(n);
      check("second_half", n, half_cycles);
    end
    ticks(6);
  endtask

  initial begin : stim
    int ok, n;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_press", int'(press), 0);
    @(posedge clk) #2 rst_n = 1'b1;
    @(negedge clk);
    ticks(3);

    // Clean press held 10 ticks.
    n_press = 0;
    btn = 1'b1;
    wait_press(ok);
    check("clean_press_seen", ok, 1);
    check("clean_mode", int'(mode), 1);
    check("clean_led", int'(led), 1);
    ticks(6);
    btn = 1'b0;
    ticks(8);
    check("clean_one_pulse", n_press, 1);

    // Bounce every 2 ticks never reaches 3 stable samples.
    n_press = 0;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      ticks(2);
      btn = 1'b0;
      ticks(2);
    end
    ticks(6);
    check("bounce_no_press", n_press, 0);
    check("bounce_mode", int'(mode), 1);

    // Mode wrap with blink half-periods in clock cycles.
    do_press(2, SH * TD);
    do_press(3, FH * TD);
    do_press(0, 0);
    do_press(1, 0);

    // Press in BLINK_SLOW at phase 5: fast blink restarts lit for a full half-period.
    btn = 1'b1;
    wait_press(ok);
    check("mid_enter_slow", int'(mode), 2);
    btn = 1'b0;
    ticks(3);
    btn = 1'b1;
    wait_press(ok);
    check("mid_press_seen", ok, 1);
    check("mid_mode", int'(mode), 3);
    check("mid_led", int'(led), 1);
    btn = 1'b0;
    led_interval(n);
    check("mid_first_toggle", n, FH * TD);
    ticks(6);

    // Randomized button activity, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      btn = logic'($urandom_range(0, 1));
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end
    btn = 1'b0;
    ticks(6);

    // Reset mid-blink with the button held through reset release.
    for (int i = 0; i < 4 && mode != 2'd2; i++) begin
      btn = 1'b1;
      wait_press(ok);
      btn = 1'b0;
      ticks(5);
    end
    check("pre_reset_blink", int'(mode), 2);
    ticks(3);
    btn = 1'b1;
    @(posedge clk) #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_press", int'(press), 0);
    repeat (2) @(negedge clk);
    n_press = 0;
    @(posedge clk) #2 rst_n = 1'b1;
    @(negedge clk);
    ticks(10);
    check("held_no_press", n_press, 0);
    check("held_mode", int'(mode), 0);
    btn = 1'b0;
    ticks(4);
    btn = 1'b1;
    wait_press(ok);
    check("repress_seen", ok, 1);
    check("repress_mode", int'(mode), 1);
    btn = 1'b0;
    ticks(6);

    // Long hold from OFF.
    @(posedge clk) #2 rst_n = 1'b0;
    @(posedge clk) #2 rst_n = 1'b1;
    @(negedge clk);
    ticks(3);
    btn = 1'b1;
    wait_press(ok);
    check("long_press_seen", ok, 1);
    check("long_first_mode", int'(mode), 1);
    n = 0;
    while (mode == 2'd1 && n < 120) begin
      @(negedge clk);
      n++;
    end
    if (LongEn != 0) begin
      check("long_force_cycles", n, LT * TD);
      check("long_force_mode", int'(mode), 0);
      check("long_force_led", int'(led), 0);
    end else begin
      check("long_no_force_mode", int'(mode), 1);
      check("long_no_force_led", int'(led), 1);
    end
    btn = 1'b0;
    ticks(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
